// File: rtl/tic_tac_toe_pkg.sv
// Shared cell/result codes, FSM states and board type for the tic-tac-toe referee.
// Optional feature macro used by the top: TTT_DRAW_DETECT_EN.
package tic_tac_toe_pkg;

    localparam int NUM_CELLS = 9;

    localparam logic [1:0] CELL_EMPTY    = 2'b00;
    localparam logic [1:0] CELL_PLAYER   = 2'b01;
    localparam logic [1:0] CELL_COMPUTER = 2'b10;

    localparam logic [1:0] WHO_NONE     = 2'b00;
    localparam logic [1:0] WHO_PLAYER   = 2'b01;
    localparam logic [1:0] WHO_COMPUTER = 2'b10;
    localparam logic [1:0] WHO_DRAW     = 2'b11;

    typedef enum logic [1:0] {
        PLAYER_TURN   = 2'b00,
        COMPUTER_TURN = 2'b01,
        GAME_DONE     = 2'b10
    } state_t;

    typedef logic [NUM_CELLS-1:0][1:0] board_t;

    // Out-of-range indices never match a cell, so they read as "not free".
    function automatic logic cell_is_free(input board_t board, input logic [3:0] idx);
        logic free;
        free = 1'b0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (idx == i[3:0] && board[i] == CELL_EMPTY) begin
                free = 1'b1;
            end
        end
        return free;
    endfunction

endpackage

// File: rtl/ttt_win_detect.sv
// Combinational evaluation of the 8 winning lines and board fullness.
module ttt_win_detect
    import tic_tac_toe_pkg::*;
(
    input  board_t board,
    output logic   player_win,
    output logic   computer_win,
    output logic   board_full
);

    localparam logic [3:0] LINES [8][3] = '{
        '{4'd0, 4'd1, 4'd2}, '{4'd3, 4'd4, 4'd5}, '{4'd6, 4'd7, 4'd8},
        '{4'd0, 4'd3, 4'd6}, '{4'd1, 4'd4, 4'd7}, '{4'd2, 4'd5, 4'd8},
        '{4'd0, 4'd4, 4'd8}, '{4'd2, 4'd4, 4'd6}
    };

    always_comb begin
        player_win   = 1'b0;
        computer_win = 1'b0;
        board_full   = 1'b1;
        for (int l = 0; l < 8; l++) begin
            if (board[LINES[l][0]] == CELL_PLAYER &&
                board[LINES[l][1]] == CELL_PLAYER &&
                board[LINES[l][2]] == CELL_PLAYER) begin
                player_win = 1'b1;
            end
            if (board[LINES[l][0]] == CELL_COMPUTER &&
                board[LINES[l][1]] == CELL_COMPUTER &&
                board[LINES[l][2]] == CELL_COMPUTER) begin
                computer_win = 1'b1;
            end
        end
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (board[i] == CELL_EMPTY) begin
                board_full = 1'b0;
            end
        end
    end

endmodule

// File: rtl/tic_tac_toe_game.sv
// Tic-tac-toe referee: board storage, turn order, move legality and result.
// Define TTT_DRAW_DETECT_EN to report a full board with no winner as who = 11.
module tic_tac_toe_game
    import tic_tac_toe_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       play,
    input  logic       pc,
    input  logic [3:0] computer_position,
    input  logic [3:0] player_position,
    output logic [1:0] pos1,
    output logic [1:0] pos2,
    output logic [1:0] pos3,
    output logic [1:0] pos4,
    output logic [1:0] pos5,
    output logic [1:0] pos6,
    output logic [1:0] pos7,
    output logic [1:0] pos8,
    output logic [1:0] pos9,
    output logic [1:0] who
);

    state_t     r_state;
    state_t     w_state_next;
    board_t     r_board;
    board_t     w_board_next;
    logic [1:0] r_who;
    logic [1:0] w_who_next;

    logic       w_player_win;
    logic       w_computer_win;
    logic       w_board_full;
    logic       w_move_en;
    logic [3:0] w_move_idx;
    logic [1:0] w_move_cell;

    ttt_win_detect u_win_detect (
        .board        (r_board),
        .player_win   (w_player_win),
        .computer_win (w_computer_win),
        .board_full   (w_board_full)
    );

    // Result checks outrank move requests, so a move is never taken on the
    // edge that reports a finished game.
    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        w_state_next = r_state;
        w_who_next   = r_who;
        w_move_en    = 1'b0;
        w_move_idx   = 4'd0;
        w_move_cell  = CELL_EMPTY;

        case (r_state)
            PLAYER_TURN, COMPUTER_TURN: begin
                if (w_player_win) begin
                    w_who_next   = WHO_PLAYER;
                    w_state_next = GAME_DONE;
                end else if (w_computer_win) begin
                    w_who_next   = WHO_COMPUTER;
                    w_state_next = GAME_DONE;
                end else if (w_board_full) begin
`ifdef TTT_DRAW_DETECT_EN
                    w_who_next   = WHO_DRAW;
`endif
                    w_state_next = GAME_DONE;
                end else if (r_state == PLAYER_TURN) begin
                    if (play && cell_is_free(r_board, player_position)) begin
                        w_move_en    = 1'b1;
                        w_move_idx   = player_position;
                        w_move_cell  = CELL_PLAYER;
                        w_state_next = COMPUTER_TURN;
                    end
                end else if (pc && cell_is_free(r_board, computer_position)) begin
                    w_move_en    = 1'b1;
                    w_move_idx   = computer_position;
                    w_move_cell  = CELL_COMPUTER;
                    w_state_next = PLAYER_TURN;
                end
            end
            default: ;
        endcase

        w_board_next = r_board;
        for (int i = 0; i < NUM_CELLS; i++) begin
            if (w_move_en && w_move_idx == i[3:0]) begin
                w_board_next[i] = w_move_cell;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the board is a small register file, so it is cleared on reset like any flop.
            r_state <= PLAYER_TURN;
            r_board <= '0;
            r_who   <= WHO_NONE;
        end else begin
            r_state <= w_state_next;
            r_board <= w_board_next;
            r_who   <= w_who_next;
        end
    end

    assign pos1 = r_board[0];
    assign pos2 = r_board[1];
    assign pos3 = r_board[2];
    assign pos4 = r_board[3];
    assign pos5 = r_board[4];
    assign pos6 = r_board[5];
    assign pos7 = r_board[6];
    assign pos8 = r_board[7];
    assign pos9 = r_board[8];
    assign who  = r_who;

endmodule

// File: tb/tb_tic_tac_toe_game.sv
// Self-checking bench: directed game scenarios plus random play against a rule-level model.
module tb_tic_tac_toe_game;

    logic       clock;
    logic       reset;
    logic       play;
    logic       pc;
    logic [3:0] computer_position;
    logic [3:0] player_position;
    logic [1:0] pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9;
    logic [1:0] who;

    tic_tac_toe_game dut (
        .clock             (clock),
        .reset             (reset),
        .play              (play),
        .pc                (pc),
        .computer_position (computer_position),
        .player_position   (player_position),
        .pos1              (pos1),
        .pos2              (pos2),
        .pos3              (pos3),
        .pos4              (pos4),
        .pos5              (pos5),
        .pos6              (pos6),
        .pos7              (pos7),
        .pos8              (pos8),
        .pos9              (pos9),
        .who               (who)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: marks 0 empty, 1 player, 2 computer; phase 0 player, 1 computer, 2 over.
    int m_board [9];
    int m_who;
    int m_phase;

    function automatic int winner_of_board();
        int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                             '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
        for (int l = 0; l < 8; l++) begin
            int a, b, c;
            a = m_board[lines[l][0]];
            b = m_board[lines[l][1]];
            c = m_board[lines[l][2]];
            if (a != 0 && a == b && b == c) return a;
        end
        return 0;
    endfunction

    function automatic int filled_cells();
        int n = 0;
        for (int i = 0; i < 9; i++) if (m_board[i] != 0) n++;
        return n;
    endfunction

    task automatic model_clock(input bit rst, input bit p, input bit c,
                               input int ppos, input int cpos);
        int w;
        if (rst) begin
            for (int i = 0; i < 9; i++) m_board[i] = 0;
            m_who   = 0;
            m_phase = 0;
            return;
        end
        if (m_phase == 2) return;
        w = winner_of_board();
        if (w != 0) begin
            m_who   = w;
            m_phase = 2;
            return;
        end
        if (filled_cells() == 9) begin
`ifdef TTT_DRAW_DETECT_EN
            m_who = 3;
`endif
            m_phase = 2;
            return;
        end
        if (m_phase == 0) begin
            if (p && ppos <= 8 && m_board[ppos] == 0) begin
                m_board[ppos] = 1;
                m_phase = 1;
            end
        end else begin
            if (c && cpos <= 8 && m_board[cpos] == 0) begin
                m_board[cpos] = 2;
                m_phase = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [1:0] observed, input logic [1:0] expected);
        n_checks++;
        assert (observed === expected) else begin
            n_errors++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic check_all();
        logic [1:0] obs [9];
        obs = '{pos1, pos2, pos3, pos4, pos5, pos6, pos7, pos8, pos9};
        for (int i = 0; i < 9; i++) begin
            check($sformatf("pos%0d", i + 1), obs[i], 2'(m_board[i]));
        end
        check("who", who, 2'(m_who));
    endtask

    // One clock: drive inputs well after the previous edge, advance model, sample #1 later.
    task automatic cyc(input bit rst, input bit p, input bit c, input int ppos, input int cpos);
        reset             = rst;
        play              = p;
        pc                = c;
        player_position   = ppos[3:0];
        computer_position = cpos[3:0];
        @(posedge clock);
        model_clock(rst, p, c, ppos, cpos);
        #1;
        check_all();
    endtask

    task automatic pmove(input int idx);
        cyc(1'b0, 1'b1, 1'b0, idx, 0);
    endtask

    task automatic cmove(input int idx);
        cyc(1'b0, 1'b0, 1'b1, 0, idx);
    endtask

    initial begin
        reset = 1'b1; play = 1'b0; pc = 1'b0;
        player_position = '0; computer_position = '0;
        for (int i = 0; i < 9; i++) m_board[i] = 0;
        m_who = 0; m_phase = 0;

        // Reset state
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0, 0, 0);
        check("reset_who", who, 2'b00);
        check("reset_pos1", pos1, 2'b00);

        // Player row win, first move right after reset
        pmove(0);
        check("first_move_pos1", pos1, 2'b01);
        cmove(4); pmove(1); cmove(8); pmove(2);
        check("row_win_who_latency", who, 2'b00);
        cmove(6);
        check("row_win_who", who, 2'b01);
        cmove(6);
        check("row_win_pos7_frozen", pos7, 2'b00);

        // Illegal and occupied computer targets
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        pmove(0);
        cmove(0);
        cmove(9);
        cmove(15);
        cyc(1'b0, 1'b1, 1'b1, 5, 0);
        check("illegal_pos6", pos6, 2'b00);
        cmove(4);
        check("legal_after_illegal_pos5", pos5, 2'b10);

        // Turn order and level-held play
        cmove(3);
        check("turn_order_pos4", pos4, 2'b00);
        for (int i = 0; i < 5; i++) pmove(7);
        check("held_play_pos8", pos8, 2'b01);
        pmove(2);
        check("held_play_single_write_pos3", pos3, 2'b00);

        // Computer diagonal win, later play ignored
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        pmove(1); cmove(0); pmove(2); cmove(4); pmove(3); cmove(8);
        pmove(5);
        check("diag_win_who", who, 2'b10);
        pmove(5);
        check("diag_win_pos6_frozen", pos6, 2'b00);

        // Draw: full board, no complete line
        cyc(1'b1, 1'b0, 1'b0, 0, 0);
        pmove(0); cmove(1); pmove(2); cmove(4); pmove(3);
        cmove(5); pmove(7); cmove(6); pmove(8);
        cyc(1'b0, 1'b1, 1'b1, 0, 0);
`ifdef TTT_DRAW_DETECT_EN
        check("draw_who", who, 2'b11);
`else
        check("draw_who", who, 2'b00);
`endif

        // Randomized games with out-of-range indices and occasional mid-game reset
        for (int g = 0; g < 25; g++) begin
            cyc(1'b1, 1'b0, 1'b0, 0, 0);
            for (int k = 0; k < 40; k++) begin
                cyc(($urandom % 64) == 0, 1'($urandom), 1'($urandom),
                    int'($urandom_range(0, 10)), int'($urandom_range(0, 10)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
